// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode, ALU opsel and immediate-format definitions shared by the issue stage
package rv32_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: sign-extended RV32I immediate extraction by format
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] inst,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);
    always_comb
        imm = (fmt == IMM_S) ? {{21{inst[31]}}, inst[30:25], inst[11:7]} :
              (fmt == IMM_B) ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
              (fmt == IMM_U) ? {inst[31:12], 12'b0} :
              (fmt == IMM_J) ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
                               {{21{inst[31]}}, inst[30:20]};
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode and ID/EX issue register behind a valid/ready handshake
// ALU_ISSUE_FORWARD_EN enables EX/MEM result forwarding onto rs1/rs2
module alu_issue_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    input  logic            i_fwd_valid,
    input  logic [4:0]      i_fwd_rd,
    input  logic [XLEN-1:0] i_fwd_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [2:0]      o_opsel,
    output logic            o_sub,
    output logic            o_unsigned,
    output logic            o_arith,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [XLEN-1:0] o_rs2_fwd,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rd,
    output logic            o_wen,
    output logic            o_branch,
    output logic [2:0]      o_funct3,
    output logic            o_illegal
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [XLEN-1:0] rs1_v, rs2_v, imm, n_op1, n_op2;
    logic [2:0] n_opsel;
    logic n_sub, n_uns, n_arith, n_branch, n_wen, n_ill;
    imm_fmt_e fmt;

    assign opc = i_inst[6:0];
    assign f3  = i_inst[14:12];
    assign rd  = i_inst[11:7];
    assign o_ready = !o_valid || i_ready;

`ifdef ALU_ISSUE_FORWARD_EN
    assign rs1_v = (i_fwd_valid && i_fwd_rd != 5'd0 && i_fwd_rd == i_inst[19:15]) ? i_fwd_data : i_rs1_data;
    assign rs2_v = (i_fwd_valid && i_fwd_rd != 5'd0 && i_fwd_rd == i_inst[24:20]) ? i_fwd_data : i_rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_fwd_valid, i_fwd_rd, i_fwd_data};
    assign rs1_v = i_rs1_data;
    assign rs2_v = i_rs2_data;
`endif

    assign fmt = (opc == OPC_LUI || opc == OPC_AUIPC) ? IMM_U :
                 (opc == OPC_STORE)                   ? IMM_S :
                 (opc == OPC_JAL)                     ? IMM_J :
                 (opc == OPC_BRANCH)                  ? IMM_B : IMM_I;

    rv32_imm_gen u_imm (.inst(i_inst[31:7]), .fmt(fmt), .imm(imm));

    always_comb begin
        n_opsel  = ALU_ADD;
        n_sub    = 1'b0;
        n_uns    = 1'b0;
        n_arith  = 1'b0;
        n_branch = 1'b0;
        n_ill    = 1'b0;
        n_wen    = rd != 5'd0;
        n_op1    = rs1_v;
        n_op2    = imm;
        case (opc)
            OPC_OP: begin
                n_opsel = f3;
                n_sub   = (f3 == 3'b000) && i_inst[30];
                n_arith = (f3 == 3'b101) && i_inst[30];
                n_uns   = f3 == 3'b011;
                n_op2   = rs2_v;
            end
            OPC_OPIMM: begin
                n_opsel = f3;
                n_arith = (f3 == 3'b101) && i_inst[30];
                n_uns   = f3 == 3'b011;
                // shifts present the bare shamt so the funct7 bits never reach the shifter
                n_op2   = (f3[1:0] == 2'b01) ? {{(XLEN-5){1'b0}}, imm[4:0]} : imm;
            end
            OPC_BRANCH: begin
                n_opsel  = ALU_SLT;
                n_uns    = f3[1];
                n_op2    = rs2_v;
                n_wen    = 1'b0;
                n_branch = 1'b1;
            end
            OPC_LUI:             n_op1 = '0;
            OPC_AUIPC, OPC_JAL:  n_op1 = i_pc;
            OPC_LOAD, OPC_JALR:  n_op1 = rs1_v;
            OPC_STORE:           n_wen = 1'b0;
            default: begin
                n_ill = 1'b1;
                n_wen = 1'b0;
                n_op1 = '0;
                n_op2 = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_opsel    <= '0;
            o_sub      <= 1'b0;
            o_unsigned <= 1'b0;
            o_arith    <= 1'b0;
            o_op1      <= '0;
            o_op2      <= '0;
            o_rs2_fwd  <= '0;
            o_pc       <= RESET_PC;
            o_rd       <= '0;
            o_wen      <= 1'b0;
            o_branch   <= 1'b0;
            o_funct3   <= '0;
            o_illegal  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            o_valid    <= 1'b1;
            o_opsel    <= n_opsel;
            o_sub      <= n_sub;
            o_unsigned <= n_uns;
            o_arith    <= n_arith;
            o_op1      <= n_op1;
            o_op2      <= n_op2;
            o_rs2_fwd  <= rs2_v;
            o_pc       <= i_pc;
            o_rd       <= rd;
            o_wen      <= n_wen;
            o_branch   <= n_branch;
            o_funct3   <= f3;
            o_illegal  <= n_ill;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage against a behavioural model
module tb_alu_issue_stage;
    localparam logic [31:0] RPC = 32'h0000_0100;
    logic clk = 1'b0;
    logic i_rst, i_valid, o_ready, i_flush, i_fwd_valid, o_valid, i_ready;
    logic [31:0] i_inst, i_pc, i_rs1_data, i_rs2_data, i_fwd_data;
    logic [4:0] i_fwd_rd, o_rd;
    logic [2:0] o_opsel, o_funct3;
    logic o_sub, o_unsigned, o_arith, o_wen, o_branch, o_illegal;
    logic [31:0] o_op1, o_op2, o_rs2_fwd, o_pc;

    typedef struct packed {
        logic [2:0]  opsel;
        logic        sub, uns, arith;
        logic [31:0] op1, op2, rs2f, pc;
        logic [4:0]  rd;
        logic        wen, br;
        logic [2:0]  f3;
        logic        ill;
    } out_t;

    out_t e;
    logic ev;
    int n_cmp = 0, n_err = 0;

    alu_issue_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_flush(i_flush), .i_fwd_valid(i_fwd_valid), .i_fwd_rd(i_fwd_rd), .i_fwd_data(i_fwd_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_opsel(o_opsel), .o_sub(o_sub),
        .o_unsigned(o_unsigned), .o_arith(o_arith), .o_op1(o_op1), .o_op2(o_op2),
        .o_rs2_fwd(o_rs2_fwd), .o_pc(o_pc), .o_rd(o_rd), .o_wen(o_wen), .o_branch(o_branch),
        .o_funct3(o_funct3), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [31:0] raw, input logic [4:0] idx,
                                        input logic fv, input logic [4:0] frd, input logic [31:0] fd);
`ifdef ALU_ISSUE_FORWARD_EN
        return (fv && frd != 5'd0 && frd == idx) ? fd : raw;
`else
        return raw;
`endif
    endfunction

    function automatic out_t decode(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic [31:0] a, input logic [31:0] b);
        out_t o;
        logic [2:0] f3 = inst[14:12];
        logic [31:0] ii = 32'($signed(inst) >>> 20);
        logic [31:0] iu = inst & 32'hFFFF_F000;
        o = '0;
        o.pc = pc;
        o.rd = inst[11:7];
        o.f3 = f3;
        o.rs2f = b;
        o.wen = inst[11:7] != 5'd0;
        case (inst[6:0])
            7'h33: begin
                o.opsel = f3; o.sub = f3 == 0 && inst[30]; o.arith = f3 == 5 && inst[30];
                o.uns = f3 == 3; o.op1 = a; o.op2 = b;
            end
            7'h13: begin
                o.opsel = f3; o.arith = f3 == 5 && inst[30]; o.uns = f3 == 3; o.op1 = a;
                o.op2 = (f3 == 1 || f3 == 5) ? {27'b0, inst[24:20]} : ii;
            end
            7'h63: begin
                o.opsel = 3'd2; o.uns = f3[1]; o.op1 = a; o.op2 = b; o.wen = 1'b0; o.br = 1'b1;
            end
            7'h37: o.op2 = iu;
            7'h17: begin o.op1 = pc; o.op2 = iu; end
            7'h03, 7'h67: begin o.op1 = a; o.op2 = ii; end
            7'h23: begin o.op1 = a; o.op2 = {ii[31:5], inst[11:7]}; o.wen = 1'b0; end
            7'h6F: begin
                o.op1 = pc; o.op2 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin o.ill = 1'b1; o.wen = 1'b0; end
        endcase
        return o;
    endfunction

    task automatic cycle(input logic rst, input logic v, input logic fl, input logic rdy,
                         input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic fv, input logic [4:0] frd, input logic [31:0] fd);
        i_rst = rst; i_valid = v; i_flush = fl; i_ready = rdy; i_inst = inst; i_pc = pc;
        i_rs1_data = a; i_rs2_data = b; i_fwd_valid = fv; i_fwd_rd = frd; i_fwd_data = fd;
        #1;
        chk("ready", {31'b0, o_ready}, {31'b0, !ev || rdy});
        @(posedge clk);
        if (rst) begin
            ev = 1'b0; e = '0; e.pc = RPC;
        end else if (fl) begin
            ev = 1'b0;
        end else if (v && (!ev || rdy)) begin
            e = decode(inst, pc, fwd(a, inst[19:15], fv, frd, fd), fwd(b, inst[24:20], fv, frd, fd));
            ev = 1'b1;
        end else if (!ev || rdy) begin
            ev = 1'b0;
        end
        #1;
        chk("valid", {31'b0, o_valid}, {31'b0, ev});
        chk("opsel", {29'b0, o_opsel}, {29'b0, e.opsel});
        chk("sub", {31'b0, o_sub}, {31'b0, e.sub});
        chk("unsigned", {31'b0, o_unsigned}, {31'b0, e.uns});
        chk("arith", {31'b0, o_arith}, {31'b0, e.arith});
        chk("op1", o_op1, e.op1);
        chk("op2", o_op2, e.op2);
        chk("rs2_fwd", o_rs2_fwd, e.rs2f);
        chk("pc", o_pc, e.pc);
        chk("rd", {27'b0, o_rd}, {27'b0, e.rd});
        chk("wen", {31'b0, o_wen}, {31'b0, e.wen});
        chk("branch", {31'b0, o_branch}, {31'b0, e.br});
        chk("funct3", {29'b0, o_funct3}, {29'b0, e.f3});
        chk("illegal", {31'b0, o_illegal}, {31'b0, e.ill});
    endtask

    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h03, 7'h23, 7'h67, 7'h6F, 7'h7F};
    logic [31:0] vals [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};

    initial begin
        ev = 1'b0; e = '0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 32'h4020_8033, 32'h40, 5, 3, 0, 0, 0);
        chk("rst_pc", o_pc, RPC);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        cycle(0, 1, 0, 1, 32'h4020_8033, 32'h44, 5, 3, 0, 0, 0);
        chk("sub_sub", {31'b0, o_sub}, 32'd1);
        chk("sub_op1", o_op1, 32'd5);
        chk("sub_op2", o_op2, 32'd3);
        chk("sub_wen", {31'b0, o_wen}, 32'd0);
        cycle(0, 1, 0, 1, 32'h4030_D093, 32'h48, 32'h8000_0000, 0, 0, 0, 0);
        chk("srai_opsel", {29'b0, o_opsel}, 32'd5);
        chk("srai_arith", {31'b0, o_arith}, 32'd1);
        chk("srai_op2", o_op2, 32'd3);
        chk("srai_rd", {27'b0, o_rd}, 32'd1);
        chk("srai_wen", {31'b0, o_wen}, 32'd1);
        cycle(0, 1, 0, 1, 32'h0020_E063, 32'h4C, 1, 32'hFFFF_FFFF, 0, 0, 0);
        chk("bltu_br", {31'b0, o_branch}, 32'd1);
        chk("bltu_opsel", {29'b0, o_opsel}, 32'd2);
        chk("bltu_uns", {31'b0, o_unsigned}, 32'd1);
        chk("bltu_wen", {31'b0, o_wen}, 32'd0);
        cycle(0, 1, 0, 1, 32'h4020_8033, 32'h50, 5, 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0, 32'h0000_007F, 32'h60 + 4 * k, 9, 9, 0, 0, 0);
            chk("stall_ready", {31'b0, o_ready}, 32'd0);
            chk("stall_op1", o_op1, 32'd5);
            chk("stall_pc", o_pc, 32'h50);
        end
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("drain_valid", {31'b0, o_valid}, 32'd0);
        cycle(0, 1, 0, 1, 32'h4020_8033, 32'h70, 5, 3, 0, 0, 0);
        cycle(0, 1, 1, 0, 32'h0030_D093, 32'h74, 7, 7, 0, 0, 0);
        chk("flush_valid", {31'b0, o_valid}, 32'd0);
        cycle(0, 1, 0, 1, 32'h0000_007F, 32'h78, 1, 2, 0, 0, 0);
        chk("illegal", {31'b0, o_illegal}, 32'd1);
        chk("illegal_wen", {31'b0, o_wen}, 32'd0);
`ifdef ALU_ISSUE_FORWARD_EN
        cycle(0, 1, 0, 1, 32'h0011_01B3, 32'h80, 32'h55, 32'h66, 1, 2, 32'h1234);
        chk("fwd_op1", o_op1, 32'h1234);
        cycle(0, 1, 0, 1, 32'h0011_01B3, 32'h84, 32'h55, 32'h66, 1, 0, 32'h1234);
        chk("fwd_rd0_op1", o_op1, 32'h55);
`endif
        for (int k = 0; k < 600; k++) begin
            logic [31:0] inst;
            inst = $urandom;
            inst[6:0] = opcs[$urandom_range(0, 9)];
            if (inst[6:0] == 7'h7F && $urandom_range(0, 1) == 1) inst[6:0] = 7'($urandom);
            if ($urandom_range(0, 1) == 1) inst[19:15] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) inst[24:20] = 5'($urandom_range(0, 3));
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, inst, $urandom,
                  vals[$urandom_range(0, 5)] ^ ($urandom_range(0, 1) == 1 ? $urandom : 32'h0),
                  vals[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), $urandom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
